// File: rtl/asi_arb_if.sv
// asi_arb_if - handshake bundle between the AXI slave read/write user
// interfaces (master side) and the read/write arbiter (slave side).
//   usr_wrequest/usr_we/usr_wlast : write burst request, beat, last flag
//   usr_rrequest/usr_re/usr_rlast : read burst request, beat, last flag
//   usr_wgrant/usr_rgrant         : registered, mutually exclusive grants
//   arb_owner/arb_busy/arb_err    : current/last owner, grant active, violation pulse
interface asi_arb_if;
   logic usr_wrequest;
   logic usr_we;
   logic usr_wlast;
   logic usr_wgrant;
   logic usr_rrequest;
   logic usr_re;
   logic usr_rlast;
   logic usr_rgrant;
   logic arb_owner;
   logic arb_busy;
   logic arb_err;

   modport master (
      output usr_wrequest, usr_we, usr_wlast,
      output usr_rrequest, usr_re, usr_rlast,
      input  usr_wgrant, usr_rgrant, arb_owner, arb_busy, arb_err
   );

   modport slave (
      input  usr_wrequest, usr_we, usr_wlast,
      input  usr_rrequest, usr_re, usr_rlast,
      output usr_wgrant, usr_rgrant, arb_owner, arb_busy, arb_err
   );
endinterface

// File: rtl/asi_arb.sv
// asi_arb - read/write arbiter for the shared user-side memory port.
// A grant is held for a whole burst (grant .. last beat); an unstarted
// burst whose request drops is abandoned. Fixed priority from ASI_ARB
// (0 = write first). Defining ASI_ARB_FAIR_EN adds a starvation limiter
// that hands one burst to the lower-priority side after ARB_MAXB
// contested wins of the priority side.
// Ports:
//   usr_clk     : clock
//   usr_reset_n : synchronous active-low reset
//   bus         : asi_arb_if.slave (requests/beats in, grants/status out)
module asi_arb #(
   parameter int unsigned ASI_ARB  = 0,
   parameter int unsigned ARB_MAXB = 4,
   parameter int unsigned ARB_CW   = $clog2(ARB_MAXB + 1)
) (
   input  logic     usr_clk,
   input  logic     usr_reset_n,
   asi_arb_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OWN_W = 2'd1;
   localparam logic [1:0] OWN_R = 2'd2;

   localparam logic PRIO_R = (ASI_ARB != 0);

   // Elaboration-time parameter sanity check
   if (ARB_MAXB == 0 || ARB_MAXB > 255 || (ARB_MAXB >> ARB_CW) != 0) begin : g_bad_cfg
      $error("asi_arb: ARB_MAXB must be 1..255 and fit in ARB_CW bits");
   end

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       started;
   logic       started_nxt;
   logic       owner_nxt;
   logic       err_nxt;
   logic       decide;
   logic       both;
   logic       flip;
   logic       win_w;
   logic       win_r;

`ifdef ASI_ARB_FAIR_EN
   localparam logic [ARB_CW-1:0] CNT_MAX = ARB_CW'(ARB_MAXB);
   logic [ARB_CW-1:0] arb_cnt;
   logic [ARB_CW-1:0] arb_cnt_nxt;
`endif

   // Next-state, winner selection and started/owner/err bookkeeping
   always_comb begin
      state_nxt   = state;
      started_nxt = started;
      owner_nxt   = bus.arb_owner;
      decide      = 1'b0;
      win_w       = 1'b0;
      win_r       = 1'b0;
      both        = bus.usr_wrequest & bus.usr_rrequest;
      flip        = 1'b0;
`ifdef ASI_ARB_FAIR_EN
      arb_cnt_nxt = arb_cnt;
      flip        = both & (arb_cnt == CNT_MAX);
`endif
      err_nxt = (bus.usr_we & ~bus.usr_wgrant) | (bus.usr_re & ~bus.usr_rgrant);

      // Release: last beat, or request withdrawn before the first beat
      case (state)
         IDLE:    decide = bus.usr_wrequest | bus.usr_rrequest;
         OWN_W:   decide = (bus.usr_we & bus.usr_wlast) | (~bus.usr_wrequest & ~started);
         OWN_R:   decide = (bus.usr_re & bus.usr_rlast) | (~bus.usr_rrequest & ~started);
         default: decide = 1'b1;
      endcase

      if (both) begin
         win_r = PRIO_R ^ flip;
         win_w = ~win_r;
      end else begin
         win_w = bus.usr_wrequest;
         win_r = bus.usr_rrequest;
      end

      if (decide) begin
         started_nxt = 1'b0;
         if (win_w)      state_nxt = OWN_W;
         else if (win_r) state_nxt = OWN_R;
         else            state_nxt = IDLE;
         if (win_w | win_r) owner_nxt = win_r;
`ifdef ASI_ARB_FAIR_EN
         // Count contested wins of the priority side; anything else clears
         if (both && !flip && arb_cnt != CNT_MAX) arb_cnt_nxt = arb_cnt + ARB_CW'(1);
         else if (!(both && !flip))               arb_cnt_nxt = '0;
`endif
      end else if ((state == OWN_W && bus.usr_we) || (state == OWN_R && bus.usr_re)) begin
         started_nxt = 1'b1;
      end
   end

   // State register and registered outputs
   always_ff @(posedge usr_clk) begin
      if (!usr_reset_n) begin
         state          <= IDLE;
         started        <= 1'b0;
         bus.usr_wgrant <= 1'b0;
         bus.usr_rgrant <= 1'b0;
         bus.arb_owner  <= 1'b0;
         bus.arb_busy   <= 1'b0;
         bus.arb_err    <= 1'b0;
`ifdef ASI_ARB_FAIR_EN
         arb_cnt        <= '0;
`endif
      end else begin
         state          <= state_nxt;
         started        <= started_nxt;
         bus.usr_wgrant <= (state_nxt == OWN_W);
         bus.usr_rgrant <= (state_nxt == OWN_R);
         bus.arb_owner  <= owner_nxt;
         bus.arb_busy   <= (state_nxt != IDLE);
         bus.arb_err    <= err_nxt;
`ifdef ASI_ARB_FAIR_EN
         arb_cnt        <= arb_cnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_asi_arb.sv
// tb_asi_arb - scoreboard bench for asi_arb: directed scenarios followed by
// randomized request/beat traffic, predicted by a burst-level model.
module tb_asi_arb;
   localparam int unsigned ARB  = 0;
   localparam int unsigned MAXB = 4;
   localparam int          FAIR_N = 25;

   logic usr_clk = 1'b0;
   logic usr_reset_n;
   always #5 usr_clk = ~usr_clk;

   asi_arb_if bus ();

   asi_arb #(.ASI_ARB(ARB), .ARB_MAXB(MAXB)) dut (
      .usr_clk     (usr_clk),
      .usr_reset_n (usr_reset_n),
      .bus         (bus)
   );

   typedef struct {
      bit wg; bit rg; bit own; bit busy; bit err; bit tag;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   obs_reads = 0;

   // Model: holder 0 = nobody, 1 = write side, 2 = read side
   int holder = 0;
   bit m_started = 0;
   bit m_owner = 0;
   int m_cnt = 0;

   function automatic int prio_side();
      return (ARB == 0) ? 1 : 2;
   endfunction

   function automatic int pick(bit wr, bit rr);
      if (wr && rr) begin
`ifdef ASI_ARB_FAIR_EN
         if (m_cnt == int'(MAXB)) return 3 - prio_side();
`endif
         return prio_side();
      end
      if (wr) return 1;
      if (rr) return 2;
      return 0;
   endfunction

   // Drive one cycle of inputs and queue the predicted outputs after the edge
   task automatic step(input bit rn, input bit wr, input bit we, input bit wl,
                       input bit rr, input bit re, input bit rl, input bit tag = 1'b0);
      exp_t e;
      bit   release_now;
      int   w;
      @(negedge usr_clk);
      usr_reset_n      = rn;
      bus.usr_wrequest = wr; bus.usr_we = we; bus.usr_wlast = wl;
      bus.usr_rrequest = rr; bus.usr_re = re; bus.usr_rlast = rl;
      e.err = 1'b0;
      if (!rn) begin
         holder = 0; m_started = 0; m_owner = 0; m_cnt = 0;
      end else begin
         e.err = (we && holder != 1) || (re && holder != 2);
         if (holder == 0)      release_now = wr || rr;
         else if (holder == 1) release_now = (we && wl) || (!wr && !m_started);
         else                  release_now = (re && rl) || (!rr && !m_started);
         if (release_now) begin
            w = pick(wr, rr);
            if (wr && rr && w == prio_side()) m_cnt = (m_cnt < int'(MAXB)) ? m_cnt + 1 : m_cnt;
            else                              m_cnt = 0;
            if (w != 0) m_owner = (w == 2);
            holder = w;
            m_started = 0;
         end else if ((holder == 1 && we) || (holder == 2 && re)) begin
            m_started = 1;
         end
      end
      e.wg = (holder == 1); e.rg = (holder == 2);
      e.own = m_owner; e.busy = (holder != 0); e.tag = tag;
      sbq.push_back(e);
   endtask

   // Monitor: compare every registered output cycle against the queue head
   initial begin
      exp_t e;
      forever begin
         @(posedge usr_clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_chk++;
            if (bus.usr_wgrant !== e.wg || bus.usr_rgrant !== e.rg || bus.arb_owner !== e.own ||
                bus.arb_busy !== e.busy || bus.arb_err !== e.err) begin
               n_fail++;
               $display("FAIL outputs @%0t: got wg=%b rg=%b own=%b busy=%b err=%b, expected wg=%b rg=%b own=%b busy=%b err=%b",
                        $time, bus.usr_wgrant, bus.usr_rgrant, bus.arb_owner, bus.arb_busy, bus.arb_err,
                        e.wg, e.rg, e.own, e.busy, e.err);
            end
            if (e.tag && bus.usr_rgrant === 1'b1) obs_reads++;
         end
      end
   end

   bit pend[2];
   bit drop[2];
   int blen[2];
   int done[2];

   initial begin
      bit rn;
      bit rq[2];
      bit bt[2];
      bit ls[2];
      int exp_reads;

      usr_reset_n = 1'b0;
      bus.usr_wrequest = 0; bus.usr_we = 0; bus.usr_wlast = 0;
      bus.usr_rrequest = 0; bus.usr_re = 0; bus.usr_rlast = 0;

      // Reset, idle, read grant, reset mid-burst, read grant again
      step(0,0,0,0,0,0,0); step(0,0,0,0,0,0,0);
      step(1,0,0,0,0,0,0);
      step(1,0,0,0,1,0,0);
      step(1,0,0,0,1,1,0);
      step(0,0,0,0,1,1,0);
      step(1,0,0,0,1,0,0);
      step(1,0,0,0,0,0,0);

      // Both request: write first, 4-beat write, then read with no gap
      step(0,0,0,0,0,0,0);
      step(1,1,0,0,1,0,0);
      step(1,1,1,0,1,0,0); step(1,1,1,0,1,0,0); step(1,1,1,0,1,0,0);
      step(1,1,1,1,1,0,0);
      // Single-beat read while still requesting: grant stays
      step(1,0,0,0,1,1,1);
      step(1,0,0,0,1,1,1);
      step(1,0,0,0,0,0,0);

      // Abandon before first beat, then drop after beat 1 (grant holds)
      step(1,1,0,0,0,0,0);
      step(1,0,0,0,1,0,0);
      step(1,0,0,0,0,0,0);
      step(1,1,0,0,0,0,0);
      step(1,1,1,0,0,0,0);
      step(1,0,0,0,1,0,0);
      step(1,0,0,0,1,0,0);
      step(1,0,1,1,1,0,0);
      step(1,0,0,0,0,0,0);

      // Read beat during write grant: one-cycle error, state unchanged
      step(1,1,0,0,0,0,0);
      step(1,1,0,0,0,1,0);
      step(1,1,0,0,0,0,0);
      step(1,1,1,1,0,0,0);
      step(1,0,0,0,0,0,0);

      // Continuous contention with single-beat bursts
      step(0,0,0,0,0,0,0);
      for (int i = 0; i < FAIR_N; i++)
         step(1,1,(holder == 1),(holder == 1),1,(holder == 2),(holder == 2),1'b1);
      step(0,0,0,0,0,0,0);

      // Randomized traffic
      for (int s = 0; s < 2; s++) begin pend[s] = 0; drop[s] = 0; blen[s] = 0; done[s] = 0; end
      for (int c = 0; c < 3000; c++) begin
         rn = ($urandom_range(0, 199) != 0);
         for (int s = 0; s < 2; s++) begin
            if (!pend[s] && $urandom_range(0, 2) == 0) begin
               pend[s] = 1; drop[s] = 0; blen[s] = int'($urandom_range(1, 4)); done[s] = 0;
            end
            if (pend[s] && !drop[s] && $urandom_range(0, 19) == 0) drop[s] = 1;
            if (drop[s] && done[s] == 0) pend[s] = 0;
            rq[s] = pend[s] && !drop[s];
            bt[s] = 0; ls[s] = 0;
            if (pend[s] && holder == s + 1 && $urandom_range(0, 9) < 6) begin
               bt[s] = 1; done[s]++; ls[s] = (done[s] == blen[s]);
               if (ls[s]) pend[s] = 0;
            end else if (holder != s + 1 && $urandom_range(0, 49) == 0) begin
               bt[s] = 1; ls[s] = 1'($urandom_range(0, 1));
            end
         end
         step(rn, rq[0], bt[0], ls[0], rq[1], bt[1], ls[1]);
         if (!rn) for (int s = 0; s < 2; s++) pend[s] = 0;
      end
      step(1,0,0,0,0,0,0);

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge usr_clk);
      #2;
      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end

`ifdef ASI_ARB_FAIR_EN
      exp_reads = FAIR_N / (int'(MAXB) + 1);
`else
      exp_reads = 0;
`endif
      n_chk++;
      if (obs_reads != exp_reads) begin
         n_fail++;
         $display("FAIL fairness: read grants %0d, expected %0d", obs_reads, exp_reads);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/asi_arb.md
# asi_arb

Read/write arbiter for the user-side memory port shared by the AXI slave write and read interfaces. Takes the `usr_wrequest` and `usr_rrequest` strobes and returns `usr_wgrant` and `usr_rgrant`. A grant is held for a whole burst: from grant until the beat that carries the last flag. Fixed priority is set by `ASI_ARB`; an optional starvation limiter can override it. Sits in the user clock domain next to the two interfaces, ahead of the shared user memory or register file.

## Interface
- `ASI_ARB`, 0: 0 = write has higher priority; otherwise read has higher priority.
- `ARB_MAXB`, 4: consecutive bursts the priority side may win while the other side waits (fairness build only); range 1..255.
- `ARB_CW`, `$clog2(ARB_MAXB+1)`: width of the fairness counter (derived).

Ports:
- `usr_clk` in 1: the single clock.
- `usr_reset_n` in 1: reset; synchronous, active-low.
- `usr_wrequest` in 1: write side has a pending burst.
- `usr_we` in 1: write beat issued.
- `usr_wlast` in 1: qualifies `usr_we` as the last beat of the burst.
- `usr_wgrant` out 1: write side owns the port.
- `usr_rrequest` in 1: read side has a pending burst.
- `usr_re` in 1: read beat issued.
- `usr_rlast` in 1: qualifies `usr_re` as the last beat of the burst.
- `usr_rgrant` out 1: read side owns the port.
- `arb_owner` out 1: 0 = write owns or last owned; 1 = read.
- `arb_busy` out 1: one grant is asserted.
- `arb_err` out 1: one-cycle pulse flagging a protocol violation.

## Operation
- Three states:
  - `IDLE`: no grant.
  - `OWN_W`: `usr_wgrant`=1.
  - `OWN_R`: `usr_rgrant`=1.
- Grants are registered and mutually exclusive. `arb_busy` = `usr_wgrant | usr_rgrant`.
- A decision is made in `IDLE` whenever a request is high, and at every release event.
- Decision rule:
  - Only one side requests: that side wins.
  - Both request: the priority side wins, unless the fairness override applies (see Configuration).
  - No request: go to `IDLE`.
- Release events for the owner:
  - (a) A last beat: `usr_we&usr_wlast` in `OWN_W`, or `usr_re&usr_rlast` in `OWN_R`.
  - (b) Abandon: the owner's request is low while the `started` flag is 0.
- `started` flag:
  - Cleared on every grant.
  - Set on the first owner beat.
  - A single-beat burst (beat and last in the same cycle) is a release under (a).
- Once `started` is 1, dropping the request does not release. Only the last beat releases.
- `arb_owner` updates on each grant and holds its value through `IDLE`.
- `arb_err` pulses the cycle after either violation:
  - `usr_we` while `usr_wgrant`=0;
  - `usr_re` while `usr_rgrant`=0.
- The state does not change on a violation.

## Timing
- Reset: an edge with `usr_reset_n`=0 forces `IDLE`, both grants 0, `arb_owner` 0, `arb_busy` 0, `arb_err` 0, `started` 0, counter 0.
- Reset mid-burst: grants drop at the next edge. There is no burst completion.
- Latency from `IDLE`: request high in cycle N → grant high in cycle N+1.
- Release in cycle M:
  - New winner is the other side: its grant rises in M+1, with no idle cycle; the old grant falls in M+1.
  - New winner is the same side: its grant stays high.
  - No request: both grants are 0 in M+1.
- Requests are sampled in the release cycle M itself.
- Simultaneous requests from `IDLE` are resolved in the same cycle as a release decision.
- The arbiter does not gate beats. Beats outside a grant are only flagged through `arb_err`.

## Configuration
- Macro: `ASI_ARB_FAIR_EN`.
- Defined: the starvation limiter is compiled in.
  - `arb_cnt` (`ARB_CW` bits) increments at each decision where the priority side wins while the other side requests.
  - It clears when the other side wins, or when the other side is not requesting at a decision.
  - When `arb_cnt`==`ARB_MAXB` and both request, the other side wins and `arb_cnt` clears.
  - It saturates at `ARB_MAXB`.
- Undefined: strict fixed priority. `arb_cnt` is absent, and the lower-priority side can starve indefinitely.

## Test plan
- Reset then idle, with `usr_reset_n` pulsed low mid-burst → all outputs 0 the next cycle. After that, a `usr_rrequest` → `usr_rgrant` high one cycle later.
- `ASI_ARB`=0, both requesting from `IDLE` → `usr_wgrant` at N+1. After a 4-beat write with `usr_wlast` on beat 4 → `usr_rgrant` high the next cycle, `usr_wgrant` low, no gap.
- Single-beat read (`usr_re`&`usr_rlast` in the first granted cycle), read request still high → `usr_rgrant` stays continuously high for the next burst.
- Abandon: grant write, drop `usr_wrequest` before any `usr_we`, read pending → `usr_rgrant` next cycle. Drop the request after beat 1 instead → the grant holds until `usr_wlast`.
- `usr_re` while `usr_wgrant`=1 → `arb_err` = 1 for exactly one cycle, and the state is unchanged.
- `ASI_ARB_FAIR_EN` defined, `ARB_MAXB`=4, `ASI_ARB`=0, both sides requesting continuously → write wins 4 bursts, read wins the 5th, the pattern repeats. Macro undefined → read never granted.
